// File: rtl/fft16_pkg.sv
// fft16_pkg
//   Shared constants and types for the 16-point radix-2 FFT sequencing
//   controller and anything that models it.
//   FFT_POINTS    number of complex samples per transform
//   FFT_STAGES    number of decimation-in-time stages (log2 of FFT_POINTS)
//   BF_PER_STAGE  butterflies issued per stage (FFT_POINTS / 2)
//   ADDR_W        sample-buffer address width
//   TW_W          twiddle index width (index k selects W16^k)
//   fft16_ctrl_state_t  controller FSM state encoding
package fft16_pkg;

  localparam int FFT_POINTS   = 16;
  localparam int FFT_STAGES   = 4;
  localparam int BF_PER_STAGE = 8;
  localparam int ADDR_W       = 4;
  localparam int TW_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft16_ctrl_state_t;

endpackage

// File: rtl/fft16_addr_gen.sv
// fft16_addr_gen
//   Combinational butterfly address generator for an in-place radix-2
//   decimation-in-time FFT over 16 points.
//   stage  in   current stage s, 0..3
//   bf     in   butterfly index b within the stage, 0..7
//   addr0  out  first input/output of the pair: grp*2*span + pos
//   addr1  out  second of the pair: addr0 + span
//   tw     out  twiddle index: pos << (3 - s)
//   with span = 2^s, pos = b mod span, grp = b >> s.
module fft16_addr_gen
  import fft16_pkg::*;
(
  input  logic [1:0]        stage,
  input  logic [2:0]        bf,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [TW_W-1:0]   tw
);

  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;

  always_comb begin
    span  = ADDR_W'(1) << stage;
    // span is a power of two, so masking with span-1 is b mod span
    pos   = ADDR_W'(bf) & (span - ADDR_W'(1));
    grp   = ADDR_W'(bf) >> stage;
    // grp * 2 * span == grp << (s + 1); pos < span so OR equals add
    addr0 = (grp << ({1'b0, stage} + 3'd1)) | pos;
    addr1 = addr0 + span;
    // pos < 2^s, so pos << (3 - s) always fits in TW_W bits
    tw    = TW_W'(pos << (2'd3 - stage));
  end

endmodule

// File: rtl/fft16_ctrl.sv
// fft16_ctrl
//   Sequencing controller for the 16-point radix-2 FFT core. Drives one
//   shared butterfly through 4 stages of 8 butterflies, issuing a read
//   address pair and twiddle index per cycle, and replays the read
//   addresses BF_LAT cycles later as the write-back addresses.
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      start one transform; only honoured in IDLE
//   o_busy       high in ISSUE, DRAIN and DONE
//   o_done       one-cycle pulse, result complete in bank 0
//   o_stage      current stage 0..3
//   o_bank       read bank; writes target ~o_bank
//   o_rd_en      butterfly issue strobe
//   o_rd_addr0/1 butterfly input pair (0 when o_rd_en = 0)
//   o_tw_idx     twiddle index (0 when o_rd_en = 0)
//   o_wr_en      write-back strobe
//   o_wr_addr0/1 butterfly output pair (0 when o_wr_en = 0)
//   o_dbg_state  FSM state register, fft16_ctrl_state_t encoding
//
//   Handshake: i_start is a level sampled on the rising edge while the FSM
//   is in IDLE; there is no ready/ack and requests seen while busy are
//   dropped, never queued.
//
//   Every output is a flop. The read-side outputs are loaded from the
//   next-state values so that they line up with the FSM state they belong
//   to in the same cycle.
module fft16_ctrl #(
  parameter int ADDR_W = fft16_pkg::ADDR_W,
  parameter int TW_W   = fft16_pkg::TW_W,
  // butterfly pipeline latency, legal range 1..7
  parameter int BF_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_stage,
  output logic              o_bank,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr0,
  output logic [ADDR_W-1:0] o_rd_addr1,
  output logic [TW_W-1:0]   o_tw_idx,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr0,
  output logic [ADDR_W-1:0] o_wr_addr1,
  output logic [1:0]        o_dbg_state
);

  import fft16_pkg::*;

  localparam logic [2:0] BF_LAST    = 3'(BF_PER_STAGE - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);
  localparam logic [1:0] STAGE_LAST = 2'(FFT_STAGES - 1);

  fft16_ctrl_state_t state_q, state_n;
  logic [1:0] stage_q, stage_n;
  logic [2:0] bf_q, bf_n;
  logic [2:0] drain_q, drain_n;
  logic       bank_q, bank_n;
  logic       rd_en_n;

  logic [fft16_pkg::ADDR_W-1:0] ag_addr0;
  logic [fft16_pkg::ADDR_W-1:0] ag_addr1;
  logic [fft16_pkg::TW_W-1:0]   ag_tw;

  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr0_q;
  logic [ADDR_W-1:0] rd_addr1_q;
  logic [TW_W-1:0]   tw_q;

  // {rd_en, addr0, addr1} delayed by the butterfly latency
  logic [2*ADDR_W:0] dly_q [BF_LAT];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      drain_q <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      stage_q <= stage_n;
      bf_q    <= bf_n;
      drain_q <= drain_n;
      bank_q  <= bank_n;
    end
  end

  always_comb begin
    state_n = state_q;
    stage_n = stage_q;
    bf_n    = bf_q;
    drain_n = drain_q;
    bank_n  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_n = ST_ISSUE;
          stage_n = '0;
          bf_n    = '0;
          bank_n  = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (bf_q == BF_LAST) begin
          state_n = ST_DRAIN;
          drain_n = '0;
        end else begin
          bf_n = bf_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        // the last write of the stage lands in this final DRAIN cycle,
        // so the bank may flip at its end
        if (drain_q == DRAIN_LAST) begin
          bank_n = ~bank_q;
          if (stage_q != STAGE_LAST) begin
            stage_n = stage_q + 2'd1;
            bf_n    = '0;
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          drain_n = drain_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    rd_en_n = (state_n == ST_ISSUE);
  end

  // Addresses for the butterfly that will be issued next cycle
  fft16_addr_gen u_addr_gen (
    .stage (stage_n),
    .bf    (bf_n),
    .addr0 (ag_addr0),
    .addr1 (ag_addr1),
    .tw    (ag_tw)
  );

  // -------------------------------------------------- registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_q       <= '0;
    end else begin
      busy_q     <= (state_n != ST_IDLE);
      done_q     <= (state_n == ST_DONE);
      rd_en_q    <= rd_en_n;
      rd_addr0_q <= rd_en_n ? ADDR_W'(ag_addr0) : '0;
      rd_addr1_q <= rd_en_n ? ADDR_W'(ag_addr1) : '0;
      tw_q       <= rd_en_n ? TW_W'(ag_tw) : '0;
    end
  end

  // ---------------------------------------------------------- write path
  // Reads carry zero addresses when idle, so the delayed writes do too.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BF_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {rd_en_q, rd_addr0_q, rd_addr1_q};
      for (int i = 1; i < BF_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign {o_wr_en, o_wr_addr0, o_wr_addr1} = dly_q[BF_LAT-1];

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_stage     = stage_q;
  assign o_bank      = bank_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr0  = rd_addr0_q;
  assign o_rd_addr1  = rd_addr1_q;
  assign o_tw_idx    = tw_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fft16_ctrl.sv
// tb_fft16_ctrl
//   Self-checking bench for fft16_ctrl with BF_LAT = 2. Expected reads and
//   writes of a transform come from an independent arithmetic model and are
//   queued when i_start is driven; they are popped as cycles elapse. A table
//   of spot vectors pins selected cycles of the run.
module tb_fft16_ctrl;

  localparam int L        = 2;
  localparam int DONE_CYC = 1 + 4 * (8 + L);
  localparam int NSPOT    = 10;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       o_busy, o_done, o_bank, o_rd_en, o_wr_en;
  logic [1:0] o_stage, o_dbg_state;
  logic [3:0] o_rd_addr0, o_rd_addr1, o_wr_addr0, o_wr_addr1;
  logic [2:0] o_tw_idx;

  fft16_ctrl #(.ADDR_W(4), .TW_W(3), .BF_LAT(L)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_stage     (o_stage),
    .o_bank      (o_bank),
    .o_rd_en     (o_rd_en),
    .o_rd_addr0  (o_rd_addr0),
    .o_rd_addr1  (o_rd_addr1),
    .o_tw_idx    (o_tw_idx),
    .o_wr_en     (o_wr_en),
    .o_wr_addr0  (o_wr_addr0),
    .o_wr_addr1  (o_wr_addr1),
    .o_dbg_state (o_dbg_state)
  );

  // ------------------------------------------------ clock/reset block
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- scoreboard
  // entry: {cycle[20:13], stage[12:11], addr0[10:7], addr1[6:3], tw[2:0]}
  logic [20:0] exp_rd_q[$];
  logic [20:0] exp_wr_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  hold_start;
  int  rd_count, wr_count;
  int  touch_rd [4][16];
  int  touch_wr [4][16];

  typedef struct {
    int         cyc;
    logic       rd_en;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [2:0] tw;
    logic [1:0] stage;
    logic       bank;
    logic       chk_stage;
  } spot_t;
  spot_t spots [NSPOT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] model_entry(input int cyc, input int s, input int b);
    int span;
    int a0;
    int a1;
    int tw;
    span = 1 << s;
    a0   = (b / span) * 2 * span + (b % span);
    a1   = a0 + span;
    tw   = (b % span) * (8 / span);
    return {8'(cyc), 2'(s), 4'(a0), 4'(a1), 3'(tw)};
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {o_busy, o_done, o_stage, o_bank, o_rd_en, o_rd_addr0, o_rd_addr1,
                 o_tw_idx, o_wr_en, o_wr_addr0, o_wr_addr1, o_dbg_state}, 32'd0);
  endtask

  // ------------------------------------------------------ driver tasks
  // Called at a negedge while the DUT is idle; that cycle is cycle 0.
  task automatic start_transform(input bit hold);
    int rc;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        rc = 1 + s * (8 + L) + b;
        exp_rd_q.push_back(model_entry(rc, s, b));
        exp_wr_q.push_back(model_entry(rc + L, s, b));
      end
    end
    rd_count = 0;
    wr_count = 0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) begin
        touch_rd[s][a] = 0;
        touch_wr[s][a] = 0;
      end
    hold_start = hold;
    i_start    = 1'b1;
  endtask

  // Advance to cycle c and compare every output against the model.
  task automatic step_check(input int c);
    logic [20:0] e;
    logic        exp_rd;
    logic        exp_wr;
    @(posedge i_clk);
    @(negedge i_clk);
    if (!hold_start) i_start = 1'b0;

    exp_rd = (exp_rd_q.size() > 0) && (exp_rd_q[0][20:13] == 8'(c));
    check($sformatf("rd_en_c%0d", c), o_rd_en, exp_rd);
    if (exp_rd) begin
      e = exp_rd_q.pop_front();
      check($sformatf("rd_data_c%0d", c),
            {o_stage, o_bank, o_rd_addr0, o_rd_addr1, o_tw_idx},
            {e[12:11], e[11], e[10:0]});
    end else begin
      check($sformatf("rd_zero_c%0d", c), {o_rd_addr0, o_rd_addr1, o_tw_idx}, 32'd0);
    end

    exp_wr = (exp_wr_q.size() > 0) && (exp_wr_q[0][20:13] == 8'(c));
    check($sformatf("wr_en_c%0d", c), o_wr_en, exp_wr);
    if (exp_wr) begin
      e = exp_wr_q.pop_front();
      check($sformatf("wr_data_c%0d", c), {o_bank, o_wr_addr0, o_wr_addr1},
            {e[11], e[10:3]});
    end else begin
      check($sformatf("wr_zero_c%0d", c), {o_wr_addr0, o_wr_addr1}, 32'd0);
    end

    check($sformatf("busy_c%0d", c), o_busy, (c >= 1) && (c <= DONE_CYC));
    check($sformatf("done_c%0d", c), o_done, c == DONE_CYC);

    if (o_rd_en === 1'b1) begin
      rd_count++;
      touch_rd[o_stage][o_rd_addr0]++;
      touch_rd[o_stage][o_rd_addr1]++;
    end
    if (o_wr_en === 1'b1) begin
      wr_count++;
      touch_wr[o_stage][o_wr_addr0]++;
      touch_wr[o_stage][o_wr_addr1]++;
    end

    for (int i = 0; i < NSPOT; i++) begin
      if (spots[i].cyc == c) begin
        check($sformatf("spot_c%0d", c),
              {o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_idx, o_bank},
              {spots[i].rd_en, spots[i].a0, spots[i].a1, spots[i].tw, spots[i].bank});
        if (spots[i].chk_stage)
          check($sformatf("spot_stage_c%0d", c), o_stage, spots[i].stage);
      end
    end
  endtask

  task automatic finish_run(input string tag);
    int bad;
    check({tag, "_rd_left"}, exp_rd_q.size(), 32'd0);
    check({tag, "_wr_left"}, exp_wr_q.size(), 32'd0);
    check({tag, "_rd_count"}, rd_count, 32'd32);
    check({tag, "_wr_count"}, wr_count, 32'd32);
    bad = 0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        if (touch_rd[s][a] != 1 || touch_wr[s][a] != 1) bad++;
    // each address appears once as a read and once as a write per stage
    check({tag, "_touch"}, bad, 32'd0);
  endtask

  // ------------------------------------------------------------ test
  initial begin
    spots[0] = '{1,  1'b1, 4'd0, 4'd1,  3'd0, 2'd0, 1'b0, 1'b1};
    spots[1] = '{8,  1'b1, 4'd14, 4'd15, 3'd0, 2'd0, 1'b0, 1'b1};
    spots[2] = '{9,  1'b0, 4'd0, 4'd0,  3'd0, 2'd0, 1'b0, 1'b1};
    spots[3] = '{11, 1'b1, 4'd0, 4'd2,  3'd0, 2'd1, 1'b1, 1'b1};
    spots[4] = '{12, 1'b1, 4'd1, 4'd3,  3'd4, 2'd1, 1'b1, 1'b1};
    spots[5] = '{21, 1'b1, 4'd0, 4'd4,  3'd0, 2'd2, 1'b0, 1'b1};
    spots[6] = '{26, 1'b1, 4'd9, 4'd13, 3'd2, 2'd2, 1'b0, 1'b1};
    spots[7] = '{34, 1'b1, 4'd3, 4'd11, 3'd3, 2'd3, 1'b1, 1'b1};
    spots[8] = '{38, 1'b1, 4'd7, 4'd15, 3'd7, 2'd3, 1'b1, 1'b1};
    spots[9] = '{41, 1'b0, 4'd0, 4'd0,  3'd0, 2'd0, 1'b0, 1'b0};

    hold_start = 1'b0;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset_state");
    i_rst = 1'b0;

    // idle after reset release
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      check_all_zero($sformatf("idle_%0d", i));
    end

    // one full transform
    start_transform(1'b0);
    for (int c = 1; c <= 45; c++) step_check(c);
    finish_run("full");

    // i_start held high: ignored while busy, accepted in the IDLE at 42
    start_transform(1'b1);
    for (int c = 1; c <= 42; c++) step_check(c);
    finish_run("hold");
    @(posedge i_clk);
    @(negedge i_clk);
    check("b2b_first_read", {o_busy, o_rd_en, o_stage, o_bank, o_rd_addr0, o_rd_addr1, o_tw_idx},
          {1'b1, 1'b1, 2'd0, 1'b0, 4'd0, 4'd1, 3'd0});
    i_start    = 1'b0;
    hold_start = 1'b0;
    i_rst      = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // reset during stage 1 issue: asserted in cycle 15, released in cycle 17
    start_transform(1'b0);
    for (int c = 1; c <= 14; c++) step_check(c);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge i_clk);
    check_all_zero("rst_c15");
    @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("rst_c16");
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      check($sformatf("post_rst_wr_en_%0d", i), o_wr_en, 1'b0);
      check_all_zero($sformatf("post_rst_%0d", i));
    end

    // restart reproduces the whole sequence
    start_transform(1'b0);
    for (int c = 1; c <= 45; c++) step_check(c);
    finish_run("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
